// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell and a registered borrow, LSB first.
// Operands are loaded in parallel on start, the result is returned in parallel with a done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             borrow_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             done_out
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;
    logic             cell_d;
    logic             cell_br;
    logic [WIDTH-1:0] res_shift;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        cell_d    = a_q[0] ^ b_q[0] ^ br_q;
        cell_br   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_shift = {cell_d, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    br_d    = borrow_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = cell_br;
                res_d = res_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    diff_d   = res_shift;
                    borrow_d = cell_br;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign ready_out  = (state_q == StIdle);
    assign busy_out   = (state_q == StRun);
    assign diff_out   = diff_q;
    assign borrow_out = borrow_q;
    assign done_out   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, bin8, ready8, busy8, bout8, done8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bin16, ready16, busy16, bout16, done16;
    logic [15:0] a16, b16, diff16;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start8), .a_in(a8), .b_in(b8),
        .borrow_in(bin8), .ready_out(ready8), .busy_out(busy8), .diff_out(diff8),
        .borrow_out(bout8), .done_out(done8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start16), .a_in(a16), .b_in(b16),
        .borrow_in(bin16), .ready_out(ready16), .busy_out(busy16), .diff_out(diff16),
        .borrow_out(bout16), .done_out(done16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation; optionally checks latency/pulse width and scrambles inputs during RUN.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input bit full, input bit toggle);
        logic [8:0] expv;
        logic [7:0] prev;
        int         lat;
        bit         seen;
        expv = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        prev = diff8;
        lat  = 0;
        seen = 0;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        if (full) check("busy_after_accept", busy8, 1);
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (toggle) begin
                a8 = 8'($urandom()); b8 = 8'($urandom());
                bin8 = 1'($urandom()); start8 = 1'($urandom());
            end
            @(posedge clk); #1;
            if (done8) begin
                seen = 1;
                lat  = k;
            end else if (toggle) begin
                check("diff_held", diff8, prev);
            end
        end
        start8 = 1'b0;
        check("done_seen", seen, 1);
        if (full) check("latency", lat, 8);
        check("diff8", diff8, expv[7:0]);
        check("borrow8", bout8, expv[8]);
        if (full) begin
            @(posedge clk); #1;
            check("done_one_cycle", done8, 0);
            check("ready_after", ready8, 1);
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin);
        logic [16:0] expv;
        bit          seen;
        expv = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        seen = 0;
        @(negedge clk);
        a16 = a; b16 = b; bin16 = bin; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            @(posedge clk); #1;
            if (done16) seen = 1;
        end
        check("done16_seen", seen, 1);
        check("diff16", diff16, expv[15:0]);
        check("borrow16", bout16, expv[16]);
    endtask

    initial begin
        int k1, k2;
        bit any_done;
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start16 = 0; a16 = 0; b16 = 0; bin16 = 0;
        #12;
        check("rst_ready", ready8, 1);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_borrow", bout8, 0);
        check("rst_ready16", ready16, 1);
        @(negedge clk);
        rst_n = 1'b1;

        op8(8'h5A, 8'h3C, 1'b0, 1, 0);
        check("dir_5a_3c", diff8, 8'h1E);
        op8(8'h00, 8'h01, 1'b0, 1, 0);
        check("dir_00_01", {bout8, diff8}, 9'h1FF);
        op8(8'h10, 8'h10, 1'b1, 1, 0);
        check("dir_eq_b1", {bout8, diff8}, 9'h1FF);
        op8(8'h10, 8'h10, 1'b0, 1, 0);
        check("dir_eq_b0", {bout8, diff8}, 9'h000);

        // Back-to-back with start held high; inputs changed during RUN must be ignored.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h80; b8 = 8'h7F;
        check("b2b_busy", busy8, 1);
        check("b2b_not_ready", ready8, 0);
        k1 = -1; k2 = -1;
        for (int k = 1; k <= 40 && k2 < 0; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                if (k1 < 0) begin
                    k1 = k;
                    check("b2b_first_diff", diff8, 8'hFF);
                    check("b2b_first_borrow", bout8, 0);
                end else begin
                    k2 = k;
                    start8 = 1'b0;
                    check("b2b_second_diff", diff8, 8'h01);
                    check("b2b_second_borrow", bout8, 0);
                end
            end
        end
        start8 = 1'b0;
        check("b2b_first_lat", k1, 8);
        check("b2b_spacing", k2 - k1, 9);
        @(posedge clk); #1;

        op8(8'h00, 8'h01, 1'b0, 0, 0);
        op8(8'hC3, 8'h5E, 1'b1, 0, 1);
        op8(8'h21, 8'hE4, 1'b0, 0, 1);

        // Asynchronous reset after 3 RUN edges aborts the operation.
        @(negedge clk);
        a8 = 8'h44; b8 = 8'h22; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ready8, 1);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_diff", diff8, 0);
        check("mid_rst_borrow", bout8, 0);
        any_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8) any_done = 1;
            if (k == 2) rst_n = 1'b1;
        end
        check("mid_rst_no_done", any_done, 0);
        op8(8'h33, 8'h11, 1'b0, 1, 0);
        check("after_rst", {bout8, diff8}, 9'h022);

        op16(16'h1234, 16'h1235, 1'b0);
        op16(16'hABCD, 16'h0BCD, 1'b1);

        for (int i = 0; i < 1000; i++)
            op8(8'($urandom()), 8'($urandom()), 1'($urandom()), 0, 0);
        for (int i = 0; i < 1000; i++)
            op16(16'($urandom()), 16'($urandom()), 1'($urandom()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - borrow, LSB first: one full-subtractor cell plus a registered borrow.
- Inverse arithmetic counterpart to the team's adder cells; used where area matters more than latency, e.g. counters and compare paths in small control datapaths.
- Operands are loaded in parallel via a start/ready handshake, processed over WIDTH cycles, and returned in parallel with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  request to start an operation; sampled only when ready_out=1.
- a_in  input  WIDTH  minuend, captured on the accepting edge.
- b_in  input  WIDTH  subtrahend, captured on the accepting edge.
- borrow_in  input  1  initial borrow, captured on the accepting edge.
- ready_out  output  1  high when idle and able to accept start_in.
- busy_out  output  1  high while an operation is in progress (RUN).
- diff_out  output  WIDTH  result; updated only on completion, held otherwise.
- borrow_out  output  1  final borrow (1 means a < b + borrow_in); updated with diff_out.
- done_out  output  1  one-cycle pulse, high when diff_out/borrow_out are updated.

Behaviour:
- Reset: asynchronous assertion (rst_n_in=0) forces state=IDLE, ready_out=1, busy_out=0, done_out=0, diff_out=0, borrow_out=0.
  - Internal shift registers, borrow register and bit counter are cleared.
  - Reset mid-operation aborts the operation; no done_out and no result update.
  - Deassertion is synchronous to clk_in; the first start_in is accepted on the first rising edge after deassertion.
- States: IDLE, RUN.
- IDLE:
  - ready_out=1, busy_out=0.
  - On an edge with start_in=1: capture a_in/b_in into shift registers, borrow_in into the borrow register, counter=0, go to RUN.
  - start_in=0: stay in IDLE, no register changes.
- RUN:
  - ready_out=0, busy_out=1.
  - Each edge uses a0/b0 as the current LSBs of the shift registers and br as the borrow register.
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the result shift register; the a and b registers shift right by 1; counter increments.
  - On the edge where counter == WIDTH-1 (the WIDTH-th RUN edge):
    - load the final result into diff_out and br_next into borrow_out;
    - set done_out=1 and go to IDLE (ready_out=1).
  - start_in is ignored throughout RUN; a/b/borrow inputs changing during RUN have no effect.
- done_out:
  - Registered; high for exactly the one cycle after the completing edge, then low.
  - If start_in=1 during the done_out cycle, it is accepted at the next edge, so back-to-back operations start every WIDTH+1 cycles.
- Latency:
  - Accept on edge E0 -> diff_out/borrow_out/done_out valid after edge E(WIDTH).
  - Throughput: one operation per WIDTH+1 cycles.
- Arithmetic: {borrow_out, diff_out} equals (2^WIDTH + a - b - borrow_in) with the top bit inverted.
  - diff_out = (a - b - borrow_in) mod 2^WIDTH.
  - borrow_out = 1 iff a < b + borrow_in (unsigned).
- Boundary conditions:
  - a == b with borrow_in=0 gives 0, borrow 0.
  - a == b with borrow_in=1 gives all-ones, borrow 1.
  - The counter never exceeds WIDTH-1.
  - No X propagation from uncaptured inputs.

Test Plan:
- Reset, then start with a=0x5A, b=0x3C, borrow_in=0 (WIDTH=8) -> done_out pulses exactly 8 edges after accept; diff_out=0x1E, borrow_out=0.
- a=0x00, b=0x01, borrow_in=0 -> diff_out=0xFF, borrow_out=1; a=0x10, b=0x10, borrow_in=1 -> diff_out=0xFF, borrow_out=1.
- Back-to-back: start held high continuously with operands 0xFF-0x00 then 0x80-0x7F -> results 0xFF/0 then 0x01/0; second done_out 9 cycles after first; start_in ignored while busy_out=1.
- Reset asserted asynchronously mid-RUN (after 3 edges) -> outputs immediately return to reset values, no done_out; a fresh operation 0x33-0x11 afterwards -> 0x22, borrow 0.
- Operand inputs toggled randomly during RUN -> result still matches the values captured at accept; diff_out and borrow_out stay unchanged between done pulses.
- 1000 random operands at WIDTH=8 and WIDTH=16 -> every result matches the reference model (a-b-borrow_in) mod 2^WIDTH and the borrow rule.
